scan_index_gen: RTL

SCAN_INDEX_GEN -- requirements
Module: scan_index_gen

---
 rtl/scan_index_gen_if.sv | 20 ++
 rtl/scan_index_gen.sv | 122 ++++++++++++
 2 files changed

// File: rtl/scan_index_gen_if.sv
// rtl/scan_index_gen_if.sv - scan index generator control/offer bundle
interface scan_index_gen_if;
    logic       en;
    logic [7:0] mask;
    logic       idx_ready;
    logic [2:0] idx;
    logic       idx_valid;
    logic       wrap;
    logic       busy;

    modport master (
        output en, mask, idx_ready,
        input  idx, idx_valid, wrap, busy
    );

    modport slave (
        input  en, mask, idx_ready,
        output idx, idx_valid, wrap, busy
    );
endinterface

// File: rtl/scan_index_gen.sv
// rtl/scan_index_gen.sv - round-robin channel index offer with per-index dwell
module scan_index_gen #(
    parameter int unsigned DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    scan_index_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_DWELL = 2'd2
    } state_e;

    localparam logic [15:0] DWELL_LOAD = 16'(DWELL - 1);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        expired_q, expired_d;
    logic        valid_q, valid_d;
    logic        wrap_q, wrap_d;
    logic        busy_q, busy_d;

    logic [2:0]  low_idx;
    logic [2:0]  next_idx;
    logic        mask_any;

    // Lowest set bit for a fresh start; next set bit after idx_q (idx_q itself last) for rotation.
    always_comb begin
        low_idx  = 3'd0;
        next_idx = idx_q;
        mask_any = |bus.mask;
        for (int i = 7; i >= 0; i--) begin
            if (bus.mask[i]) begin
                low_idx = 3'(i);
            end
        end
        for (int k = 8; k >= 1; k--) begin
            if (bus.mask[idx_q + 3'(k)]) begin
                next_idx = idx_q + 3'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        expired_d = expired_q;
        wrap_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.en && mask_any) begin
                    idx_d   = low_idx;
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (bus.idx_ready) begin
                    if (bus.en) begin
                        state_d   = S_DWELL;
                        cnt_d     = DWELL_LOAD;
                        expired_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DWELL: begin
                // One settle cycle after the counter reaches zero: offer period is DWELL+2.
                if (!bus.en) begin
                    state_d = S_IDLE;
                end else if (expired_q) begin
                    if (mask_any) begin
                        idx_d   = next_idx;
                        wrap_d  = (next_idx <= idx_q);
                        state_d = S_OFFER;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == 16'd0) begin
                    expired_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        valid_d = (state_d == S_OFFER);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            cnt_q     <= 16'd0;
            expired_q <= 1'b0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.idx       = idx_q;
    assign bus.idx_valid = valid_q;
    assign bus.wrap      = wrap_q;
    assign bus.busy      = busy_q;

endmodule
